regfile_dump: RTL and testbench

- Sequential reader that walks a contiguous range of the integer register file through one read port and streams each (address, data) pair out on a valid/ready interface.
- Sits beside `regfile` in the Milestone-2 core and drives one of its read-address inputs (rs1/rs2-style port).
- Used for architectural-state dumps at end of test, debug snapshots and checksum comparison against the reference model.
- Reports completion and an XOR checksum of all dumped words.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_dump.sv | 123 ++++++++++++
 tb/tb_regfile_dump.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file constants and dump FSM state type
package regfile_pkg;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    DONE
  } dump_state_e;
endpackage

// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - walks a register range through one read port and streams (addr, data) beats
module regfile_dump
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int DATA_W   = regfile_pkg::DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] first_addr_i,
  input  logic [ADDR_W-1:0] last_addr_i,
  output logic [ADDR_W-1:0] rf_addr_o,
  input  logic [DATA_W-1:0] rf_data_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [ADDR_W-1:0] dump_addr_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              dump_last_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] checksum_o
);

  if ((2 ** ADDR_W) < NUM_REGS) begin : g_bad_cfg
    $error("ADDR_W too narrow for NUM_REGS");
  end

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cur_q;
  logic [ADDR_W-1:0] last_q;
  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] sum_q;
  logic              handshake;

  assign handshake = valid_q && dump_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    rf_addr_o = '0;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = (first_addr_i <= last_addr_i) ? FETCH : DONE;
      end
      FETCH: begin
        busy_o    = 1'b1;
        rf_addr_o = cur_q;
        state_d   = abort_i ? IDLE : SEND;
      end
      SEND: begin
        busy_o    = 1'b1;
        rf_addr_o = cur_q;
        // abort wins over a handshake landing on the same edge
        if (abort_i)        state_d = IDLE;
        else if (handshake) state_d = (cur_q == last_q) ? DONE : FETCH;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cur_q   <= '0;
      last_q  <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      sum_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            cur_q  <= first_addr_i;
            last_q <= last_addr_i;
            sum_q  <= '0;
          end
        end
        FETCH: begin
          if (abort_i) begin
            sum_q <= '0;
          end else begin
            data_q  <= rf_data_i;
            addr_q  <= cur_q;
            valid_q <= 1'b1;
            sum_q   <= sum_q ^ rf_data_i;
          end
        end
        SEND: begin
          if (abort_i) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
          end else if (handshake) begin
            valid_q <= 1'b0;
            if (cur_q != last_q) cur_q <= cur_q + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign dump_valid_o = valid_q;
  assign dump_addr_o  = addr_q;
  assign dump_data_o  = data_q;
  assign dump_last_o  = valid_q && (addr_q == last_q);
  assign checksum_o   = sum_q;

endmodule

// File: tb/tb_regfile_dump.sv
// tb/tb_regfile_dump.sv - directed table-driven bench for regfile_dump with a behavioural regfile
module tb_regfile_dump;
  import regfile_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] first_addr;
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;
  logic              dump_last;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] checksum;

  logic [DATA_W-1:0] regs [NUM_REGS];
  int tests  = 0;
  int failed = 0;

  typedef struct {
    int first;
    int last;
    int stall_addr;
    int stall_len;
    int poke_beat;
  } dump_vec_t;

  dump_vec_t vecs [7];

  regfile_dump dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .abort_i      (abort),
    .first_addr_i (first_addr),
    .last_addr_i  (last_addr),
    .rf_addr_o    (rf_addr),
    .rf_data_i    (rf_data),
    .dump_valid_o (dump_valid),
    .dump_ready_i (dump_ready),
    .dump_addr_o  (dump_addr),
    .dump_data_o  (dump_data),
    .dump_last_o  (dump_last),
    .busy_o       (busy),
    .done_o       (done),
    .checksum_o   (checksum)
  );

  // x0 hardwired to zero, combinational read
  assign rf_data = (rf_addr == '0) ? '0 : regs[rf_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [DATA_W-1:0] model(int a);
    logic [4:0] idx;
    idx = a[4:0];
    return (idx == 5'd0) ? '0 : regs[idx];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_dump(input dump_vec_t v);
    int n_exp, exp_addr, beats, hs_cyc, stall_cnt;
    bit seen_done;
    logic [DATA_W-1:0] exp_sum;
    n_exp = (v.first <= v.last) ? v.last - v.first + 1 : 0;
    exp_sum = '0;
    for (int a = v.first; a <= v.last; a++) exp_sum ^= model(a);
    exp_addr = v.first; beats = 0; hs_cyc = -10; stall_cnt = 0; seen_done = 0;
    start = 1'b1; first_addr = 5'(v.first); last_addr = 5'(v.last); dump_ready = 1'b0;
    step();
    if (n_exp > 0) begin
      check("rf_addr_n1", rf_addr, 32'(v.first));
      check("valid_n1", dump_valid, 0);
    end
    for (int cyc = 1; cyc < 200; cyc++) begin
      start = 1'b0;
      dump_ready = 1'b0;
      if (done) begin
        check("done_beats", beats, n_exp);
        check("done_latency", cyc, (n_exp == 0) ? 1 : hs_cyc + 1);
        check("checksum", checksum, exp_sum);
        check("done_valid", dump_valid, 0);
        check("done_busy", busy, 0);
        seen_done = 1;
        step();
        check("done_pulse_width", done, 0);
        check("checksum_hold", checksum, exp_sum);
        break;
      end
      check("busy", busy, 1);
      if (dump_valid) begin
        check("beat_addr", dump_addr, exp_addr);
        check("beat_data", dump_data, model(exp_addr));
        check("beat_last", dump_last, exp_addr == v.last);
        if (beats == v.poke_beat) begin
          start = 1'b1; first_addr = 5'd20; last_addr = 5'd25;
        end
        if (exp_addr == v.stall_addr && stall_cnt < v.stall_len) begin
          stall_cnt++;
        end else begin
          dump_ready = 1'b1;
          beats++;
          hs_cyc = cyc;
          exp_addr++;
        end
      end
      step();
    end
    if (!seen_done) check("done_timeout", 0, 1);
    dump_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; dump_ready = 1'b0;
    first_addr = '0; last_addr = '0;
    for (int i = 0; i < NUM_REGS; i++) regs[i] = (32'h0101_0101 * i) ^ 32'hA5A5_0000;
    #1;
    check("reset_outputs", {dump_valid, busy, done, dump_last}, 0);
    check("reset_checksum", checksum, 0);
    check("reset_rf_addr", rf_addr, 0);
    #11 rst_n = 1'b1;
    step();
    check("idle_busy", busy, 0);

    // regfile write port, applied on a clock edge
    @(posedge clk); regs[5] = 32'h0000_007B; regs[7] = 32'hFFFF_FC18; #1;

    vecs[0] = '{0, 31, -1, 0, -1};
    vecs[1] = '{7, 8, -1, 0, -1};
    vecs[2] = '{0, 6, 3, 5, -1};
    vecs[3] = '{10, 3, -1, 0, -1};
    vecs[4] = '{2, 4, -1, 0, 1};
    vecs[5] = '{31, 31, -1, 0, -1};
    vecs[6] = '{0, 0, -1, 0, -1};
    for (int i = 0; i < 7; i++) begin
      run_dump(vecs[i]);
      step();
    end

    // abort in the SEND cycle of the 5th beat, ready high
    start = 1'b1; first_addr = 5'd0; last_addr = 5'd31;
    step();
    start = 1'b0; dump_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (dump_valid && dump_addr == 5'd4) break;
      step();
    end
    check("abort_reach_beat5", {dump_valid, dump_addr}, {1'b1, 5'd4});
    abort = 1'b1;
    step();
    abort = 1'b0; dump_ready = 1'b0;
    check("abort_valid", dump_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_checksum", checksum, 0);
    for (int c = 0; c < 3; c++) begin
      check("abort_no_done", done, 0);
      step();
    end
    run_dump('{0, 3, -1, 0, -1});
    step();

    // asynchronous reset mid-SEND
    start = 1'b1; first_addr = 5'd5; last_addr = 5'd9;
    step();
    start = 1'b0;
    step();
    check("pre_reset_valid", dump_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid_busy_done_last", {dump_valid, busy, done, dump_last}, 0);
    check("rst_addr", dump_addr, 0);
    check("rst_data", dump_data, 0);
    check("rst_checksum", checksum, 0);
    check("rst_rf_addr", rf_addr, 0);
    #3 rst_n = 1'b1;
    step();
    check("post_reset_idle", {busy, done, dump_valid}, 0);
    run_dump('{1, 2, -1, 0, -1});

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
